// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the register file's single write port between the in-order pipeline
// writeback stage (WB) and one multi-cycle unit (MC). WB has priority; MC
// results wait in a small FIFO and drain on cycles where WB does not need the
// port. If the queue sits undrained for MAX_WAIT cycles, a one-cycle pipeline
// stall (STARVE) is forced so the queue head is written.
//
// Ports
//   CLK            clock, all state updates on posedge
//   rst            synchronous reset, active-high
//   wb_valid/wb_rd/wb_data     WB stage register write request
//   mc_valid/mc_rd/mc_data     MC result offer, transferred on valid && ready
//   mc_ready       queue can accept (from registered occupancy only)
//   pipe_stall     registered; pipeline must hold its WB instruction
//   rf_write_en/rf_rd_sel/rf_write_data   register file write port (comb.)
//   q_count        registered number of queued MC results
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int WORD_SIZE  = 32,
    parameter int ADDR_LEN   = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic                                CLK,
    input  logic                                rst,
    input  logic                                wb_valid,
    input  logic [ADDR_LEN-1:0]                 wb_rd,
    input  logic [WORD_SIZE-1:0]                wb_data,
    input  logic                                mc_valid,
    output logic                                mc_ready,
    input  logic [ADDR_LEN-1:0]                 mc_rd,
    input  logic [WORD_SIZE-1:0]                mc_data,
    output logic                                pipe_stall,
    output logic                                rf_write_en,
    output logic [ADDR_LEN-1:0]                 rf_rd_sel,
    output logic [WORD_SIZE-1:0]                rf_write_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     q_count
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_STARVE = 1'b1
    } state_t;

    // Circular pointer advance; depth need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_LAST) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_ONE;
        end
        return n;
    endfunction

    state_t                r_state;
    logic                  r_stall;
    logic [WAIT_W-1:0]     r_wait;
    logic [CNT_W-1:0]      r_count;
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [ADDR_LEN-1:0]   r_q_rd   [FIFO_DEPTH];
    logic [WORD_SIZE-1:0]  r_q_data [FIFO_DEPTH];

    logic                  w_have;
    logic                  w_ready;
    logic                  w_push;
    logic                  w_wb_live;
    logic                  w_sel_wb;
    logic                  w_pop;
    logic [WAIT_W-1:0]     w_wait_next;
    logic                  w_go_starve;

    assign w_have    = (r_count != {CNT_W{1'b0}});
    assign w_ready   = (r_count < CNT_FULL);
    // Accepted results for x0 are acknowledged but never stored.
    assign w_push    = mc_valid && w_ready && (mc_rd != {ADDR_LEN{1'b0}});
    assign w_wb_live = wb_valid && !r_stall && (wb_rd != {ADDR_LEN{1'b0}});

    assign mc_ready   = w_ready;
    assign pipe_stall = r_stall;
    assign q_count    = r_count;

    // Port ownership: WB first in NORMAL, queue head otherwise or when starving.
    always_comb begin
        w_sel_wb = 1'b0;
        w_pop    = 1'b0;
        case (r_state)
            ST_NORMAL: begin
                if (w_wb_live) begin
                    w_sel_wb = 1'b1;
                end else if (w_have) begin
                    w_pop = 1'b1;
                end else begin
                    w_pop = 1'b0;
                end
            end
            ST_STARVE: begin
                if (w_have) begin
                    w_pop = 1'b1;
                end else begin
                    w_pop = 1'b0;
                end
            end
            default: begin
                w_sel_wb = 1'b0;
                w_pop    = 1'b0;
            end
        endcase
    end

    // Write port mux; idle port drives zeros, and reset suppresses any write.
    always_comb begin
        rf_write_en   = 1'b0;
        rf_rd_sel     = {ADDR_LEN{1'b0}};
        rf_write_data = {WORD_SIZE{1'b0}};
        if (rst) begin
            rf_write_en = 1'b0;
        end else if (w_sel_wb) begin
            rf_write_en   = 1'b1;
            rf_rd_sel     = wb_rd;
            rf_write_data = wb_data;
        end else if (w_pop) begin
            rf_write_en   = 1'b1;
            rf_rd_sel     = r_q_rd[r_head];
            rf_write_data = r_q_data[r_head];
        end else begin
            rf_write_en = 1'b0;
        end
    end

    // Starvation counter: counts NORMAL cycles where a non-empty queue is not popped.
    always_comb begin
        w_wait_next = {WAIT_W{1'b0}};
        if (r_state != ST_NORMAL) begin
            w_wait_next = {WAIT_W{1'b0}};
        end else if (!w_have || w_pop) begin
            w_wait_next = {WAIT_W{1'b0}};
        end else if (r_wait < WAIT_MAX) begin
            w_wait_next = r_wait + WAIT_ONE;
        end else begin
            w_wait_next = r_wait;
        end
    end

    // Reaching the limit this cycle makes the very next cycle a stall cycle.
    assign w_go_starve = (r_state == ST_NORMAL) && (w_wait_next == WAIT_MAX);

    // Arbitration FSM with registered stall output.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state <= ST_NORMAL;
            r_stall <= 1'b0;
            r_wait  <= {WAIT_W{1'b0}};
        end else begin
            case (r_state)
                ST_NORMAL: begin
                    r_wait <= w_wait_next;
                    if (w_go_starve) begin
                        r_state <= ST_STARVE;
                        r_stall <= 1'b1;
                    end else begin
                        r_state <= ST_NORMAL;
                        r_stall <= 1'b0;
                    end
                end
                ST_STARVE: begin
                    r_state <= ST_NORMAL;
                    r_stall <= 1'b0;
                    r_wait  <= {WAIT_W{1'b0}};
                end
                default: begin
                    r_state <= ST_NORMAL;
                    r_stall <= 1'b0;
                    r_wait  <= {WAIT_W{1'b0}};
                end
            endcase
        end
    end

    // Queue pointers and occupancy; push and pop together leave the count alone.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_head  <= {PTR_W{1'b0}};
            r_tail  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage; contents are don't-care while the slot is not occupied.
    always_ff @(posedge CLK) begin
        if (w_push && !rst) begin
            r_q_rd[r_tail]   <= mc_rd;
            r_q_data[r_tail] <= mc_data;
        end
    end

endmodule
